// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target with a DEPTH x 8 register file.
//   The bus is over-sampled on clk. A master writes a pointer byte and then
//   data bytes, which go to auto-incrementing register indices. A read
//   returns auto-incrementing bytes starting at the current pointer. Local
//   logic sees I2C writes as strobes and can write and read registers
//   through a side port.
// Ports:
//   clk, reset           system clock, async active-low reset
//   scl, sda             I2C bus; sda is open-drain (driven 0 or released)
//   wr_strobe/index/data one-cycle report of each committed I2C write byte
//   rd_strobe            one-cycle pulse when the master acks/nacks a read byte
//   busy                 high from address match until STOP or mismatched START
//   loc_we/addr/wdata    local register write
//   loc_rdata            reg[loc_addr], one cycle latency
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h60,
  parameter int         DEPTH         = 16,
  parameter int         PTR_W         = 4,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl,
  inout  wire              sda,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_index,
  output logic [7:0]       wr_data,
  output logic             rd_strobe,
  output logic             busy,
  input  logic             loc_we,
  input  logic [PTR_W-1:0] loc_addr,
  input  logic [7:0]       loc_wdata,
  output logic [7:0]       loc_rdata
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  // ---------------- input conditioning ----------------
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_p, sda_p;
  logic scl_rise, scl_fall, start_c, stop_c;

  // Synchronisers reset to 1 (idle bus) so reset release cannot fake a STOP/START.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_p    <= scl_s;
      sda_p    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start_c  = scl_s & sda_p & ~sda_s;
  assign stop_c   = scl_s & ~sda_p & sda_s;

  // ---------------- state ----------------
  state_t           state, state_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc;
  logic             sda_oe, sda_oe_n;
  logic             busy_n, rw, rw_n, ack, ack_n;
  logic             wr_strobe_n, rd_strobe_n;
  logic [PTR_W-1:0] wr_index_n;
  logic [7:0]       wr_data_n;
  logic             i2c_we;

  logic [7:0] regs [DEPTH];
  logic [7:0] rx_byte, ptr_byte, inc_byte;
  logic       in_range;

  assign rx_byte  = {shift[6:0], sda_s};
  assign in_range = (32'(rx_byte) < DEPTH);
  assign ptr_inc  = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  assign ptr_byte = regs[ptr];
  assign inc_byte = regs[ptr_inc];

  // Registered drive enable: the pin never depends combinationally on the bus.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      rw        <= 1'b0;
      ack       <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      wr_data   <= '0;
      rd_strobe <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      ptr       <= ptr_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      rw        <= rw_n;
      ack       <= ack_n;
      wr_strobe <= wr_strobe_n;
      wr_index  <= wr_index_n;
      wr_data   <= wr_data_n;
      rd_strobe <= rd_strobe_n;
    end
  end

  // Byte states count rising edges; bit_cnt reaches 8 after the last data
  // bit. In the ack states the first falling edge (bit_cnt==8) starts the
  // ack drive, the 9th rise bumps bit_cnt to 9, and the following fall ends
  // the ack slot and moves on.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    ptr_n       = ptr;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    rw_n        = rw;
    ack_n       = ack;
    wr_strobe_n = 1'b0;
    wr_index_n  = wr_index;
    wr_data_n   = wr_data;
    rd_strobe_n = 1'b0;
    i2c_we      = 1'b0;

    if (start_c) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else if (stop_c) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shift_n   = rx_byte;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (rx_byte[7:1] == SLAVE_ADDRESS) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
              rw_n    = rx_byte[0];
              ack_n   = 1'b1;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end

        PTR: if (scl_rise) begin
          shift_n   = rx_byte;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            state_n = PTR_ACK;
            ack_n   = in_range;
            if (in_range) ptr_n = rx_byte[PTR_W-1:0];
          end
        end

        WDATA: if (scl_rise) begin
          shift_n   = rx_byte;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            state_n     = WDATA_ACK;
            ack_n       = 1'b1;
            i2c_we      = 1'b1;
            wr_strobe_n = 1'b1;
            wr_index_n  = ptr;
            wr_data_n   = rx_byte;
          end
        end

        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n = ack;
          end else if (scl_rise) begin
            bit_cnt_n = 4'd9;
          end else if (scl_fall && bit_cnt == 4'd9) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            case (state)
              ADDR_ACK: if (rw) begin
                // First read bit goes out on this same falling edge.
                state_n  = RDATA;
                shift_n  = ptr_byte;
                sda_oe_n = ~ptr_byte[7];
              end else begin
                state_n = PTR;
              end
              PTR_ACK: state_n = ack ? WDATA : IDLE;
              default: begin
                state_n = WDATA;
                ptr_n   = ptr_inc;
              end
            endcase
          end
        end

        RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n = 1'b0;
              state_n  = RDATA_ACK;
            end else begin
              sda_oe_n = ~shift[6];
              shift_n  = {shift[6:0], 1'b0};
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise) begin
            ack_n       = ~sda_s;
            rd_strobe_n = 1'b1;
            bit_cnt_n   = 4'd9;
          end else if (scl_fall && bit_cnt == 4'd9) begin
            bit_cnt_n = '0;
            if (ack) begin
              state_n  = RDATA;
              ptr_n    = ptr_inc;
              shift_n  = inc_byte;
              sda_oe_n = ~inc_byte[7];
            end else begin
              // busy stays up until STOP or the next START
              state_n = IDLE;
            end
          end
        end

        default: ;
      endcase
    end
  end

  // ---------------- register file ----------------
  // An I2C commit to the same index as a local write wins; the byte being
  // shifted out lives in shift, so local writes cannot disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      loc_rdata <= '0;
    end else begin
      if (loc_we && !(i2c_we && loc_addr == ptr)) regs[loc_addr] <= loc_wdata;
      if (i2c_we) regs[ptr] <= rx_byte;
      loc_rdata <= regs[loc_addr];
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: a bus master built from tasks, a transaction
// level model of the register file and pointer, and one compare process
// checking strobes, bus release and the local read port on every cycle.
module tb_i2c_slave_regfile;
  localparam logic [6:0] ADR = 7'h60;
  localparam int DEPTH = 16;
  localparam int P = 6;

  logic       clk = 0;
  logic       reset;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic       wr_strobe, rd_strobe, busy;
  logic [3:0] wr_index;
  logic [7:0] wr_data, loc_rdata;
  logic       loc_we;
  logic [3:0] loc_addr;
  logic [7:0] loc_wdata;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_regfile #(.SLAVE_ADDRESS(ADR), .DEPTH(DEPTH), .PTR_W(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .wr_strobe(wr_strobe), .wr_index(wr_index), .wr_data(wr_data),
    .rd_strobe(rd_strobe), .busy(busy),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model
  logic [7:0]  mreg [DEPTH];
  logic [3:0]  mptr;
  logic [11:0] exp_wr [$];
  int          exp_rd = 0;
  int          rd_seen = 0;
  bit          chk_rel = 0;
  bit          chk_loc = 0;
  logic [7:0]  wbuf [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // compare process
  logic wr_q = 0;
  always begin
    @(posedge clk);
    #2;
    if (reset) begin
      if (wr_strobe) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected actual=%0h required=none", {wr_index, wr_data});
        end else begin
          chk("wr_event", {wr_index, wr_data}, exp_wr.pop_front());
        end
        if (wr_q) begin
          total++; bad++;
          $display("FAIL wr_pulse_width actual=2+ required=1");
        end
      end
      if (rd_strobe) rd_seen++;
      if (chk_rel && !m_low) chk("sda_released", sda, 1);
      if (chk_loc) chk("loc_rdata", loc_rdata, mreg[loc_addr]);
    end
    wr_q = wr_strobe;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b, input bit coll);
    m_low = !b; tick(P); scl = 1;
    if (coll) begin
      // local write lands on the same clk edge as the I2C commit
      @(posedge clk); @(posedge clk); @(negedge clk); loc_we = 1;
      @(negedge clk); loc_we = 0; tick(P - 3);
    end else tick(P);
    scl = 0; tick(P);
  endtask

  task automatic recv_bit(output bit b);
    m_low = 0; tick(P); scl = 1; tick(P / 2); b = sda; tick(P / 2);
    scl = 0; tick(P);
  endtask

  task automatic send_byte(input logic [7:0] v, output bit ackd, input bit coll);
    bit r;
    for (int i = 7; i >= 0; i--) send_bit(v[i], coll && i == 0);
    recv_bit(r);
    ackd = !r;
  endtask

  task automatic recv_byte(input bit do_ack, output logic [7:0] v);
    bit r;
    for (int i = 7; i >= 0; i--) begin recv_bit(r); v[i] = r; end
    send_bit(!do_ack, 0);
  endtask

  task automatic i2c_start();
    if (scl) begin
      m_low = 1; tick(P); scl = 0; tick(P);
    end else begin
      m_low = 0; tick(P); scl = 1; tick(P); m_low = 1; tick(P); scl = 0; tick(P);
    end
  endtask

  task automatic i2c_stop();
    m_low = 1; tick(P); scl = 1; tick(P); m_low = 0; tick(P);
  endtask

  task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); loc_we = 1; loc_addr = a; loc_wdata = d;
    @(negedge clk); loc_we = 0;
    mreg[a] = d;
  endtask

  task automatic loc_read(input logic [3:0] a, output logic [7:0] d);
    loc_addr = a; tick(2); d = loc_rdata;
  endtask

  task automatic sweep();
    chk_loc = 1;
    for (int i = 0; i < DEPTH; i++) begin loc_addr = 4'(i); tick(1); end
    chk_loc = 0;
  endtask

  // write pointer p then n bytes from wbuf
  task automatic wr_txn(input logic [7:0] p, input int n, input bit do_stop, input bit coll);
    bit ackd;
    i2c_start();
    send_byte({ADR, 1'b0}, ackd, 0);
    chk("addr_ack", ackd, 1);
    chk("busy_on", busy, 1);
    send_byte(p, ackd, 0);
    chk("ptr_ack", ackd, (p < DEPTH));
    if (p < DEPTH) begin
      mptr = p[3:0];
      for (int i = 0; i < n; i++) begin
        exp_wr.push_back({mptr, wbuf[i]});
        mreg[mptr] = wbuf[i];
        mptr = (mptr == DEPTH - 1) ? 4'd0 : mptr + 4'd1;
        send_byte(wbuf[i], ackd, coll && i == 0);
        chk("data_ack", ackd, 1);
      end
    end
    if (do_stop) begin
      i2c_stop(); tick(4);
      chk("busy_off", busy, 0);
      chk("wr_queue_empty", exp_wr.size(), 0);
    end
  endtask

  logic [7:0] rbuf [8];
  task automatic rd_txn(input logic [7:0] p, input int n, input bit set_ptr);
    bit ackd;
    logic [7:0] v;
    if (set_ptr) wr_txn(p, 0, 0, 0);
    i2c_start();
    send_byte({ADR, 1'b1}, ackd, 0);
    chk("raddr_ack", ackd, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i != n - 1, v);
      rbuf[i] = v;
      chk("rd_byte", v, mreg[mptr]);
      if (i != n - 1) mptr = (mptr == DEPTH - 1) ? 4'd0 : mptr + 4'd1;
    end
    exp_rd += n;
    m_low = 0; tick(2);
    chk("busy_hold_after_nack", busy, 1);
    chk("sda_rel_after_nack", sda, 1);
    i2c_stop(); tick(4);
    chk("busy_off_rd", busy, 0);
    chk("rd_count", rd_seen, exp_rd);
  endtask

  initial begin
    logic [7:0] d;
    bit ackd;
    reset = 0; scl = 1; m_low = 0;
    loc_we = 0; loc_addr = 0; loc_wdata = 0;
    for (int i = 0; i < DEPTH; i++) mreg[i] = 0;
    mptr = 0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_rd_strobe", rd_strobe, 0);
    chk("rst_wr_index", wr_index, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_loc_rdata", loc_rdata, 0);
    chk("rst_sda", sda, 1);
    reset = 1; tick(4);
    sweep();

    // basic write
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    wr_txn(8'h03, 2, 1, 0);
    loc_read(4, d); chk("t1_reg4_lit", d, 8'h5A);
    loc_read(3, d); chk("t1_reg3_lit", d, 8'hA5);

    // read with repeated start
    rd_txn(8'h03, 2, 1);
    chk("t2_b0_lit", rbuf[0], 8'hA5);
    chk("t2_b1_lit", rbuf[1], 8'h5A);
    chk("t2_rdcnt_lit", rd_seen, 2);

    // wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    wr_txn(8'h0F, 2, 1, 0);
    loc_read(15, d); chk("wrap_reg15_lit", d, 8'h11);
    loc_read(0, d);  chk("wrap_reg0_lit", d, 8'h22);

    // pointer out of range
    wr_txn(8'h10, 0, 1, 0);

    // address mismatch
    chk_rel = 1;
    i2c_start();
    send_byte(8'hC2, ackd, 0);
    chk("mm_ack", ackd, 0);
    chk("mm_busy", busy, 0);
    send_byte(8'h00, ackd, 0);
    chk("mm_ack2", ackd, 0);
    i2c_stop(); tick(4);
    chk_rel = 0;
    chk("mm_busy_end", busy, 0);
    chk("mm_rdcnt", rd_seen, exp_rd);

    // longer burst, local write, read across it with wrap
    wbuf[0] = 8'h01; wbuf[1] = 8'h80; wbuf[2] = 8'hFF; wbuf[3] = 8'h3C;
    wr_txn(8'h0D, 4, 1, 0);
    loc_write(4'h1, 8'hC3);
    rd_txn(8'h0E, 4, 1);
    chk("burst_b3_lit", rbuf[3], 8'hC3);
    sweep();

    // collision: I2C commit and local write to reg 2 on the same edge
    loc_addr = 4'd2; loc_wdata = 8'h44;
    wbuf[0] = 8'h33;
    wr_txn(8'h02, 1, 1, 1);
    loc_read(2, d); chk("coll_reg2_lit", d, 8'h33);

    // reset while the target drives a 0 bit
    loc_write(4'd5, 8'h0F);
    wr_txn(8'h05, 0, 0, 0);
    i2c_start();
    send_byte({ADR, 1'b1}, ackd, 0);
    chk("rr_ack", ackd, 1);
    chk("rr_drive0", sda, 0);
    #3; reset = 0; #1;
    chk("rr_sda", sda, 1);
    chk("rr_busy", busy, 0);
    chk("rr_wr_strobe", wr_strobe, 0);
    chk("rr_rd_strobe", rd_strobe, 0);
    chk("rr_wr_index", wr_index, 0);
    chk("rr_wr_data", wr_data, 0);
    chk("rr_loc_rdata", loc_rdata, 0);
    for (int i = 0; i < DEPTH; i++) mreg[i] = 0;
    mptr = 0;
    @(negedge clk); tick(2);
    reset = 1; tick(4);
    sweep();
    wbuf[0] = 8'h66;
    wr_txn(8'h07, 1, 1, 0);
    rd_txn(8'h07, 1, 1);
    chk("rr_fresh_lit", rbuf[0], 8'h66);

    tick(10);
    chk("final_wr_queue", exp_wr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
